// File: rtl/bsg_two_fifo_width_p64_pkg.sv
// Shared constants for the two-entry FIFO slice.
package bsg_two_fifo_width_p64_pkg;
  localparam int unsigned width_default_lp = 32'd64;
  localparam int unsigned els_lp           = 32'd2;
endpackage

// File: rtl/bsg_mem_1r1w_synth_width_p64_els_p2.sv
// Small register file: synchronous write port, asynchronous read port, cleared on reset.
module bsg_mem_1r1w_synth_width_p64_els_p2
  import bsg_two_fifo_width_p64_pkg::*;
#(
  parameter int unsigned width_p = width_default_lp,
  parameter int unsigned els_p   = els_lp,
  localparam int unsigned addr_width_lp = $clog2(els_p)
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     w_v_i,
  input  logic [addr_width_lp-1:0] w_addr_i,
  input  logic [width_p-1:0]       w_data_i,
  input  logic [addr_width_lp-1:0] r_addr_i,
  output logic [width_p-1:0]       r_data_o
);

  logic [width_p-1:0] mem_r [els_p];

  // Storage update: clear every entry on reset, otherwise write the addressed entry only.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < int'(els_p); i++) begin
        mem_r[i] <= {width_p{1'b0}};
      end
    end else if (w_v_i) begin
      mem_r[w_addr_i] <= w_data_i;
    end
  end

  assign r_data_o = mem_r[r_addr_i];

endmodule

// File: rtl/bsg_two_fifo_width_p64_chk.sv
// Protocol checker: consume only while valid, no unknowns on handshake inputs outside reset.
module bsg_two_fifo_width_p64_chk (
  input logic clk_i,
  input logic reset_n_i,
  input logic v_i,
  input logic yumi_i,
  input logic v_o
);

  a_yumi_needs_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> v_o);

  a_no_x_handshake: assert property (@(posedge clk_i) disable iff (!reset_n_i) !$isunknown({v_i, yumi_i}));

endmodule

// File: rtl/bsg_two_fifo_width_p64.sv
// Two-entry ready/valid FIFO with registered flags; head word is read straight from storage.
module bsg_two_fifo_width_p64
  import bsg_two_fifo_width_p64_pkg::*;
#(
  parameter int unsigned width_p = width_default_lp
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               ready_o,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  logic wptr_r, rptr_r, empty_r, full_r;
  logic enq_s, deq_s;

  // A consume while empty is illegal; masking it keeps state intact anyway.
  assign enq_s = v_i & ~full_r;
  assign deq_s = yumi_i & ~empty_r;

  // Pointer and occupancy-flag update.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      wptr_r  <= 1'b0;
      rptr_r  <= 1'b0;
      empty_r <= 1'b1;
      full_r  <= 1'b0;
    end else begin
      if (enq_s) wptr_r <= ~wptr_r;
      if (deq_s) rptr_r <= ~rptr_r;
      case ({enq_s, deq_s})
        2'b10: begin
          empty_r <= 1'b0;
          full_r  <= ~empty_r;
        end
        2'b01: begin
          full_r  <= 1'b0;
          empty_r <= ~full_r;
        end
        default: begin
          empty_r <= empty_r;
          full_r  <= full_r;
        end
      endcase
    end
  end

  bsg_mem_1r1w_synth_width_p64_els_p2 #(
    .width_p(width_p),
    .els_p  (els_lp)
  ) mem (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .w_v_i    (enq_s),
    .w_addr_i (wptr_r),
    .w_data_i (data_i),
    .r_addr_i (rptr_r),
    .r_data_o (data_o)
  );

  assign ready_o = ~full_r;
  assign v_o     = ~empty_r;

  bsg_two_fifo_width_p64_chk chk (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .v_i      (v_i),
    .yumi_i   (yumi_i),
    .v_o      (v_o)
  );

endmodule

// File: tb/tb_bsg_two_fifo_width_p64.sv
// Scoreboard bench for the two-entry FIFO: queue model predicts flags and head word every cycle.
module tb_bsg_two_fifo_width_p64;

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic        v_i;
  logic [63:0] data_i;
  logic        ready_o;
  logic        v_o;
  logic [63:0] data_o;
  logic        yumi_i;

  int errors = 0;
  int checks = 0;
  logic [63:0] sb [$];

  bsg_two_fifo_width_p64 #(.width_p(64)) dut (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .v_i      (v_i),
    .data_i   (data_i),
    .ready_o  (ready_o),
    .v_o      (v_o),
    .data_o   (data_o),
    .yumi_i   (yumi_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check_val("ready_o", {63'd0, ready_o}, {63'd0, (sb.size() < 2)});
    check_val("v_o", {63'd0, v_o}, {63'd0, (sb.size() > 0)});
    if (sb.size() > 0) check_val("data_o", data_o, sb[0]);
  endtask

  // One clock: drive inputs, update the model with what the edge should do, then check.
  task automatic step(input logic v, input logic [63:0] d, input logic y);
    bit do_enq, do_deq;
    v_i = v; data_i = d; yumi_i = y;
    do_enq = v && (sb.size() < 2);
    do_deq = y && (sb.size() > 0);
    @(posedge clk_i); #1;
    if (do_deq) void'(sb.pop_front());
    if (do_enq) sb.push_back(d);
    check_outputs();
  endtask

  // Hold reset with busy handshake inputs, which must be ignored.
  task automatic do_reset(input int cycles);
    reset_n_i = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      v_i = 1'b1; data_i = {$urandom, $urandom}; yumi_i = 1'b1;
      @(posedge clk_i); #1;
    end
    sb.delete();
    v_i = 1'b0; yumi_i = 1'b0;
    reset_n_i = 1'b1;
    check_val("rst_v_o", {63'd0, v_o}, 64'd0);
    check_val("rst_ready_o", {63'd0, ready_o}, 64'd1);
    check_val("rst_data_o", data_o, 64'd0);
  endtask

  initial begin
    reset_n_i = 1'b0; v_i = 1'b0; yumi_i = 1'b0; data_i = 64'd0;
    do_reset(2);
    step(1'b0, 64'd0, 1'b0);

    // Fill, overflow attempt, drain.
    step(1'b1, 64'h1111, 1'b0);
    step(1'b1, 64'h2222, 1'b0);
    check_val("full_ready", {63'd0, ready_o}, 64'd0);
    step(1'b1, 64'h3333, 1'b0);
    step(1'b0, 64'd0, 1'b1);
    step(1'b0, 64'd0, 1'b1);
    check_val("drained_v_o", {63'd0, v_o}, 64'd0);

    // Streaming 0..99 with consume whenever valid.
    for (int i = 0; i < 100; i++) begin
      step(1'b1, 64'(i), sb.size() > 0);
      check_val("stream_ready", {63'd0, ready_o}, 64'd1);
    end
    step(1'b0, 64'd0, 1'b1);

    // Full with simultaneous consume and offer: offer is dropped.
    step(1'b1, 64'h4444, 1'b0);
    step(1'b1, 64'h5555, 1'b0);
    step(1'b1, 64'hAAAA, 1'b1);
    check_val("full_deq_ready", {63'd0, ready_o}, 64'd1);
    check_val("full_deq_head", data_o, 64'h5555);
    step(1'b0, 64'd0, 1'b1);

    // Reset while holding two words; they must never appear.
    step(1'b1, 64'h6666, 1'b0);
    step(1'b1, 64'h7777, 1'b0);
    do_reset(1);
    step(1'b1, 64'h8888, 1'b0);
    check_val("post_rst_head", data_o, 64'h8888);
    step(1'b0, 64'd0, 1'b1);

    // Random stall traffic.
    for (int i = 0; i < 10000; i++) begin
      step(1'($urandom_range(0, 1)), {$urandom, $urandom},
           (sb.size() > 0) && ($urandom_range(0, 2) != 0));
    end
    while (sb.size() > 0) step(1'b0, 64'd0, 1'b1);
    check_val("final_v_o", {63'd0, v_o}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bsg_two_fifo_width_p64.md
BSG_TWO_FIFO_WIDTH_P64 -- requirements
Module: bsg_two_fifo_width_p64

Interface
REQ-001 Parameter: width_p, default 64, data width in bits of every stored entry.
REQ-002 Port: clk_i  input  1  the single clock; all state updates on its rising edge.
REQ-003 Port: reset_n_i  input  1  synchronous, active-low reset, sampled on the rising edge of clk_i.
REQ-004 Port: v_i  input  1  upstream offers a valid word on data_i.
REQ-005 Port: data_i  input  width_p  upstream data word.
REQ-006 Port: ready_o  output  1  block can accept a word this cycle; registered, not combinationally dependent on v_i or yumi_i.
REQ-007 Port: v_o  output  1  head entry is valid; registered.
REQ-008 Port: data_o  output  width_p  head entry; driven from storage registers, no combinational path from data_i.
REQ-009 Port: yumi_i  input  1  downstream consumes the head word this cycle; legal only while v_o=1.

Function
REQ-010 Storage: 2 entries of width_p bits, 1-bit write pointer, 1-bit read pointer, registered empty and full flags.
REQ-011 Enqueue event: enq = v_i & ready_o; the word is written at mem[wptr] and wptr toggles on that edge.
REQ-012 Dequeue event: deq = yumi_i; rptr toggles on that edge.
REQ-013 ready_o = ~full; v_o = ~empty; data_o = mem[rptr].
REQ-014 Latency: a word enqueued at edge N is presented on data_o with v_o=1 in the cycle after edge N (one cycle); no fall-through.
REQ-015 Occupancy transitions:
- 0 to 1 on enq only.
- 1 to 2 on enq only.
- 2 to 1 on deq only.
- 1 to 0 on deq only.
- At occupancy 1, simultaneous enq and deq keep occupancy 1 and advance both pointers.
REQ-016 Full: ready_o=0; v_i is ignored even if yumi_i=1 the same cycle; ready_o returns to 1 on the cycle after the dequeue.
REQ-017 Empty: v_o=0; yumi_i is illegal; the design ignores it and leaves state unchanged.
REQ-018 Words leave in strict arrival order; pointer wrap from 1 to 0 is seamless with no lost or duplicated word.
REQ-019 Contents of a non-head entry never change except by an enqueue into that entry.
REQ-020 Simulation assertions flag yumi_i=1 while v_o=0 and any X on v_i or yumi_i outside reset.

Reset
REQ-021 While reset_n_i=0 at a rising edge:
- wptr=0, rptr=0, empty=1, full=0.
- Both storage entries are cleared to 0.
- After that edge: v_o=0, ready_o=1, data_o=0.
REQ-022 Reset mid-operation discards all held entries without emitting them; v_i and yumi_i are ignored during reset cycles.
REQ-023 The first enqueue is accepted on the first edge with reset_n_i=1.

Structure
REQ-024 Shared package holds only the default width constant (64) and the entry count constant (2); no typedefs are required.
REQ-025 One sub-module is natural: bsg_mem_1r1w_synth_width_p64_els_p2, a 2-entry register file with a synchronous write port and an asynchronous read port; pointers and flags stay in the top module.
REQ-026 The output feeds bsg_dff_reset_width_p64 directly; no extra output register is added inside this block.

Verification
REQ-027 Reset then idle: reset_n_i=0 for 2 cycles, then 1 -> v_o=0, ready_o=1, data_o=0.
REQ-028 Fill then drain:
- Enqueue 0x1111 then 0x2222 with yumi_i=0 -> ready_o=0 after the second edge.
- v_i with 0x3333 while full is dropped.
- Dequeues then yield 0x1111, then 0x2222, then v_o=0.
REQ-029 Streaming: v_i=1 and yumi_i=v_o every cycle with an incrementing pattern 0..99 -> data_o shows 0..99 in order, one per cycle after the first, with ready_o held at 1.
REQ-030 Full with simultaneous deq and v_i: yumi_i=1 and v_i=1 (0xAAAA) -> 0xAAAA not taken; occupancy 1; ready_o=1 next cycle.
REQ-031 Reset mid-operation: two entries held, reset_n_i=0 for one cycle -> v_o=0, ready_o=1; the old words never appear on data_o.
REQ-032 Random stall: random v_i and yumi_i over 10k cycles -> scoreboard shows in-order, loss-free delivery and no assertion fires.
